// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state codes, owner ids, default widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // grant/req vectors use the owner value as the bit index
  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; bit 0 = iCache, bit 1 = dCache.
// Zero latency; a tie goes to whichever side did not own the port last.
module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWNER_IC) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between iCache and dCache: req in IDLE -> mem_req next cycle, mem_ready -> ack next cycle.
// Requesters simply hold req until ack; the memory stalls the transaction by withholding mem_ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_busy
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } mem_cmd_t;

  arb_state_t        state, state_nxt;
  owner_t            owner, last_owner;
  mem_cmd_t          cmd_q;
  logic [LINE_W-1:0] ic_rdata_q, dc_rdata_q;
  logic [1:0]        grant;

  mem_port_arbiter_rr_arb2 u_rr (
    .req   ({dc_req, ic_req}),
    .last  (last_owner),
    .grant (grant)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (|grant)   state_nxt = ARB_BUSY;
      ARB_BUSY: if (mem_ready) state_nxt = ARB_RESP;
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      owner      <= OWNER_IC;
      last_owner <= OWNER_IC;
      cmd_q      <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && |grant) begin
        owner <= grant[1] ? OWNER_DC : OWNER_IC;
        if (grant[1])
          cmd_q <= '{we: dc_we, addr: dc_addr, wdata: dc_wdata};
        else
          cmd_q <= '{we: 1'b0, addr: ic_addr, wdata: '0};
      end
      // a writeback returns no line, so dc_rdata keeps the last read
      if (state == ARB_BUSY && mem_ready) begin
        if (owner == OWNER_IC)
          ic_rdata_q <= mem_rdata;
        else if (!cmd_q.we)
          dc_rdata_q <= mem_rdata;
      end
      if (state == ARB_RESP)
        last_owner <= owner;
    end
  end

  assign mem_req   = (state == ARB_BUSY);
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign ic_ack    = (state == ARB_RESP) && (owner == OWNER_IC);
  assign dc_ack    = (state == ARB_RESP) && (owner == OWNER_DC);
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign arb_busy  = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester/memory agents plus a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_rdata;
  logic              ic_ack;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic [LINE_W-1:0] dc_rdata;
  logic              dc_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              arb_busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_ack    (ic_ack),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_rdata  (dc_rdata),
    .dc_ack    (dc_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .arb_busy  (arb_busy)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one transaction at a time, tracked by cycle numbers
  txn_t              ic_q[$];
  txn_t              dc_q[$];
  bit                ic_svc, dc_svc;
  int                cyc = 0;
  bit                m_active;
  bit                m_owner;      // 0 = iCache, 1 = dCache
  txn_t              m_txn;
  int                idle_from;
  int                ready_at;
  bit                last_served;
  logic [LINE_W-1:0] ic_rd_exp, dc_rd_exp;
  bit                prev_ic, prev_dc, ready_drv;
  logic [LINE_W-1:0] ready_dat;

  int ic_gate = 100, dc_gate = 100, drop_pct = 0, lat_fix = -1;
  bit stray_en = 0;

  task automatic model_reset();
    m_active    = 0;
    last_served = 0;
    ic_rd_exp   = '0;
    dc_rd_exp   = '0;
    prev_ic     = 0;
    prev_dc     = 0;
    ready_drv   = 0;
    ic_svc      = 0;
    dc_svc      = 0;
    idle_from   = cyc;
  endtask

  task automatic push_ic(input logic [ADDR_W-1:0] a);
    txn_t t;
    t.addr = a; t.we = 1'b0; t.wdata = '0;
    ic_q.push_back(t);
  endtask

  task automatic push_dc(input logic w, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    txn_t t;
    t.addr = a; t.we = w; t.wdata = d;
    dc_q.push_back(t);
  endtask

  task automatic step();
    bit ack_ic, ack_dc;
    @(posedge clk);
    #1;
    cyc++;
    ack_ic = 0;
    ack_dc = 0;
    if (m_active && ready_drv) begin
      m_active    = 0;
      idle_from   = cyc + 1;
      last_served = m_owner;
      if (!m_owner) begin
        ack_ic    = 1;
        ic_rd_exp = ready_dat;
      end else begin
        ack_dc = 1;
        if (!m_txn.we) dc_rd_exp = ready_dat;
      end
    end else if (!m_active && (cyc - 1) >= idle_from && (prev_ic || prev_dc)) begin
      if (prev_ic && prev_dc) m_owner = !last_served;
      else                    m_owner = prev_dc;
      if (m_owner) begin m_txn = dc_q[0]; dc_svc = 1; end
      else         begin m_txn = ic_q[0]; ic_svc = 1; end
      m_active = 1;
      ready_at = cyc + ((lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 4)));
    end

    chk("mem_req", mem_req, m_active);
    chk("arb_busy", arb_busy, m_active || ack_ic || ack_dc);
    chk("ic_ack", ic_ack, ack_ic);
    chk("dc_ack", dc_ack, ack_dc);
    chk("ic_rdata", ic_rdata, ic_rd_exp);
    chk("dc_rdata", dc_rdata, dc_rd_exp);
    if (m_active) begin
      chk("mem_addr", mem_addr, m_txn.addr);
      chk("mem_we", mem_we, m_txn.we);
      chk("mem_wdata", mem_wdata, m_txn.wdata);
    end

    if (ack_ic) begin ic_q.delete(0); ic_req = 0; ic_svc = 0; end
    if (ack_dc) begin dc_q.delete(0); dc_req = 0; dc_svc = 0; end

    mem_ready = 0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (m_active && cyc == ready_at) mem_ready = 1;
    else if (!m_active && stray_en && $urandom_range(0, 3) == 0) mem_ready = 1;
    ready_drv = mem_ready;
    ready_dat = mem_rdata;

    if (ic_req && ic_svc && $urandom_range(0, 99) < drop_pct) ic_req = 0;
    else if (!ic_req && !ic_svc && !ack_ic && ic_q.size() > 0 && $urandom_range(0, 99) < ic_gate) begin
      ic_req  = 1;
      ic_addr = ic_q[0].addr;
    end
    if (dc_req && dc_svc && $urandom_range(0, 99) < drop_pct) dc_req = 0;
    else if (!dc_req && !dc_svc && !ack_dc && dc_q.size() > 0 && $urandom_range(0, 99) < dc_gate) begin
      dc_req   = 1;
      dc_we    = dc_q[0].we;
      dc_addr  = dc_q[0].addr;
      dc_wdata = dc_q[0].wdata;
    end
    prev_ic = ic_req;
    prev_dc = dc_req;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((ic_q.size() > 0 || dc_q.size() > 0 || m_active) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", (ic_q.size() + dc_q.size() + int'(m_active)) == 0, 1'b1);
  endtask

  initial begin
    int n;
    reset = 0; ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0;
    dc_wdata = '0; mem_rdata = '0; mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_acks", {ic_ack, dc_ack}, 2'b00);
    chk("rst_ic_rdata", ic_rdata, '0);
    chk("rst_dc_rdata", dc_rdata, '0);
    chk("rst_busy", arb_busy, 1'b0);
    @(negedge clk) reset = 1;
    model_reset();

    // simultaneous requests after reset: dCache first, then strict alternation
    for (int i = 0; i < 3; i++) begin
      push_ic(32'h1000 + i * 32'h40);
      push_dc(1'b0, 32'h2000 + i * 32'h40, '0);
    end
    drain(200);

    // lone iCache read with a 4-cycle memory
    lat_fix = 4;
    push_ic(32'h100);
    drain(50);

    // dCache read, then a writeback that must leave dc_rdata alone
    lat_fix = -1;
    push_dc(1'b0, 32'h300, '0);
    push_dc(1'b1, 32'h200, {16{8'hAA}});
    drain(100);

    // back-to-back iCache requests
    lat_fix = 1;
    for (int i = 0; i < 3; i++) push_ic(32'h4000 + i * 32'h40);
    drain(100);

    // stray mem_ready while idle
    stray_en = 1;
    repeat (20) step();

    // randomized mixed traffic with mid-transaction req drops
    lat_fix = -1; ic_gate = 60; dc_gate = 60; drop_pct = 10;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 0) push_ic($urandom & 32'hFFFF_FFF0);
      else push_dc(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFF0,
                   {$urandom, $urandom, $urandom, $urandom});
    end
    drain(20000);

    // reset in the middle of a transaction, then a fresh request
    stray_en = 0; drop_pct = 0; ic_gate = 100; dc_gate = 100; lat_fix = 20;
    push_ic(32'h600);
    n = 0;
    while (!m_active && n < 10) begin step(); n++; end
    chk("rst_mid_started", m_active, 1'b1);
    step();
    reset = 0;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_busy", arb_busy, 1'b0);
    chk("rst_mid_acks", {ic_ack, dc_ack}, 2'b00);
    chk("rst_mid_ic_rdata", ic_rdata, '0);
    ic_req = 0; dc_req = 0; mem_ready = 0;
    ic_q.delete();
    dc_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    model_reset();
    lat_fix = 2;
    push_ic(32'h500);
    push_dc(1'b0, 32'h700, '0);
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
